// File: rtl/func_gen_pkg.sv
// Shared types and register map for the DDS function generator.
package func_gen_pkg;

  localparam int unsigned CFG_ADDR_W = 2;
  localparam int unsigned CFG_DATA_W = 32;

  typedef enum logic [2:0] {
    SINE     = 3'd0,
    TRIANGLE = 3'd1,
    SQUARE   = 3'd2,
    PWM      = 3'd3,
    SAW      = 3'd4
  } wave_mode_t;

  localparam logic [CFG_ADDR_W-1:0] REG_PHASE_INC = 2'd0;
  localparam logic [CFG_ADDR_W-1:0] REG_CTRL      = 2'd1;
  localparam logic [CFG_ADDR_W-1:0] REG_DUTY      = 2'd2;
  localparam logic [CFG_ADDR_W-1:0] REG_AMP       = 2'd3;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } cfg_wr_t;

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: phase accumulator, shadow/active config, 3-stage sample
// pipeline and amplitude scaling.
module dds_channel
  import func_gen_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned PHASE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  cfg_wr_t           wr,
  output logic [ADDR_W:0]   rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] wave_out,
  output logic              sync
);

  localparam int unsigned PROD_W = 2 * DATA_W + 1;

  logic [PHASE_W-1:0] phase, sh_inc, act_inc, nx_inc;
  logic [2:0]         sh_mode, act_mode, nx_mode;
  logic [DATA_W-1:0]  sh_duty, act_duty, nx_duty;
  logic [DATA_W-1:0]  sh_amp, act_amp, nx_amp;
  logic               en, en_nx, wrap_q, wrap_c;
  logic [PHASE_W:0]   sum_c;
  logic [DATA_W-1:0]  p_top_c, raw_c, raw2_c;
  logic               rom_sel_c;
  logic               s1_vld, s1_rom, s1_wrap, s2_vld, s2_rom, s2_wrap;
  logic [DATA_W-1:0]  s1_raw, s1_amp, s2_raw, s2_amp;
  logic [PROD_W-1:0]  prod_c;

  // Shadow contents as they will be after this edge's write (enable is direct)
  always_comb begin
    nx_inc  = sh_inc;
    nx_mode = sh_mode;
    nx_duty = sh_duty;
    nx_amp  = sh_amp;
    en_nx   = en;
    if (wr_en) begin
      case (wr.addr)
        REG_PHASE_INC: nx_inc = PHASE_W'(wr.data);
        REG_CTRL: begin
          nx_mode = wr.data[2:0];
          en_nx   = wr.data[3];
        end
        REG_DUTY: nx_duty = DATA_W'(wr.data);
        default:  nx_amp  = DATA_W'(wr.data);
      endcase
    end
  end

  assign sum_c   = PHASE_W'(phase) + (PHASE_W+1)'(act_inc) + (PHASE_W+1)'(0);
  assign wrap_c  = en & sum_c[PHASE_W];
  assign p_top_c = phase[PHASE_W-1 -: DATA_W];

  // Raw sample for the non-table modes; unknown modes fall through to SAW
  always_comb begin
    raw_c     = p_top_c;
    rom_sel_c = 1'b0;
    case (act_mode)
      SINE, TRIANGLE: begin
        raw_c     = '0;
        rom_sel_c = 1'b1;
      end
      SQUARE:  raw_c = phase[PHASE_W-1] ? '0 : '1;
      PWM:     raw_c = (p_top_c < act_duty) ? '1 : '0;
      default: raw_c = p_top_c;
    endcase
  end

  assign raw2_c = s2_rom ? rom_data : s2_raw;
  assign prod_c = PROD_W'(raw2_c) * (PROD_W'(s2_amp) + PROD_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_inc   <= '0;
      sh_mode  <= SINE;
      sh_duty  <= '0;
      sh_amp   <= '1;
      act_inc  <= '0;
      act_mode <= SINE;
      act_duty <= '0;
      act_amp  <= '1;
      en       <= 1'b0;
      phase    <= '0;
      wrap_q   <= 1'b0;
      s1_vld   <= 1'b0;
      s1_rom   <= 1'b0;
      s1_wrap  <= 1'b0;
      s1_raw   <= '0;
      s1_amp   <= '0;
      s2_vld   <= 1'b0;
      s2_rom   <= 1'b0;
      s2_wrap  <= 1'b0;
      s2_raw   <= '0;
      s2_amp   <= '0;
      rom_addr <= '0;
      wave_out <= '0;
      sync     <= 1'b0;
    end else begin
      sh_inc  <= nx_inc;
      sh_mode <= nx_mode;
      sh_duty <= nx_duty;
      sh_amp  <= nx_amp;
      en      <= en_nx;

      // Idle channels track the shadow live; running ones only at a wrap
      if (!en || act_inc == '0) begin
        act_inc  <= nx_inc;
        act_mode <= nx_mode;
        act_duty <= nx_duty;
        act_amp  <= nx_amp;
      end else if (wrap_c) begin
        act_inc  <= sh_inc;
        act_mode <= sh_mode;
        act_duty <= sh_duty;
        act_amp  <= sh_amp;
      end

      if (en && en_nx) begin
        phase  <= sum_c[PHASE_W-1:0];
        wrap_q <= wrap_c;
      end else begin
        phase  <= '0;
        wrap_q <= 1'b0;
      end

      if (!en_nx) begin
        s1_vld   <= 1'b0;
        s1_wrap  <= 1'b0;
        s2_vld   <= 1'b0;
        s2_wrap  <= 1'b0;
        rom_addr <= '0;
        wave_out <= '0;
        sync     <= 1'b0;
      end else begin
        s1_vld   <= en;
        s1_rom   <= rom_sel_c;
        s1_wrap  <= wrap_q;
        s1_raw   <= raw_c;
        s1_amp   <= act_amp;
        rom_addr <= en ? {act_mode == TRIANGLE, phase[PHASE_W-1 -: ADDR_W]} : '0;
        s2_vld   <= s1_vld;
        s2_rom   <= s1_rom;
        s2_wrap  <= s1_wrap;
        s2_raw   <= s1_raw;
        s2_amp   <= s1_amp;
        wave_out <= s2_vld ? DATA_W'(prod_c >> DATA_W) : '0;
        sync     <= s2_vld & s2_wrap;
      end
    end
  end

endmodule

// File: rtl/dds_func_gen.sv
// Multi-channel DDS function generator: config handshake/decode and
// per-channel packing of the table and sample buses.
module dds_func_gen
  import func_gen_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 2,
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned ADDR_W  = 10,
  parameter  int unsigned PHASE_W = 32,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [CH_W-1:0]               cfg_ch,
  input  logic [CFG_ADDR_W-1:0]         cfg_addr,
  input  logic [CFG_DATA_W-1:0]         cfg_data,
  output logic [NUM_CH*(ADDR_W+1)-1:0]  rom_addr,
  input  logic [NUM_CH*DATA_W-1:0]      rom_data,
  output logic [NUM_CH*DATA_W-1:0]      wave_out,
  output logic [NUM_CH-1:0]             sync
);

  cfg_wr_t wr;

  assign wr = '{addr: cfg_addr, data: cfg_data};

  // Ready comes up one edge after reset release and never drops
  always_ff @(posedge clk) begin
    if (!rst_n) cfg_ready <= 1'b0;
    else        cfg_ready <= 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;

    assign wr_en = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    dds_channel #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .PHASE_W (PHASE_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr       (wr),
      .rom_addr (rom_addr[i*(ADDR_W+1) +: (ADDR_W+1)]),
      .rom_data (rom_data[i*DATA_W +: DATA_W]),
      .wave_out (wave_out[i*DATA_W +: DATA_W]),
      .sync     (sync[i])
    );
  end

endmodule

// File: tb/tb_dds_func_gen.sv
// Directed self-checking bench for dds_func_gen (2 channels, 8-bit samples).
module tb_dds_func_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_ch;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [21:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] wave_out;
  logic [1:0]  sync;
  int          n_vec = 0;
  int          n_err = 0;

  dds_func_gen #(.NUM_CH(2), .DATA_W(8), .ADDR_W(10), .PHASE_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .wave_out  (wave_out),
    .sync      (sync)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return (a[7:0] * 8'd7) ^ {5'b0, a[10:8]};
  endfunction

  // Waveform table model with one cycle of read latency
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      rom_data[i*8 +: 8] <= rom_fn(rom_addr[i*11 +: 11]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic ch, input logic [1:0] a, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_addr  = a;
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_addr = 2'd1; cfg_data = 32'hA;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", cfg_ready); end
      n_vec++; if (wave_out !== 16'h0) begin n_err++; $display("FAIL reset_wave got %h want 0", wave_out); end
      n_vec++; if (rom_addr !== 22'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", rom_addr); end
      n_vec++; if (sync !== 2'b00) begin n_err++; $display("FAIL reset_sync got %b want 0", sync); end
    end
    rst_n = 1'b1;
    tick();
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_release got %b want 1", cfg_ready); end
    cfg_valid = 1'b0;
    repeat (6) tick();
    n_vec++; if (wave_out !== 16'h0) begin n_err++; $display("FAIL reset_no_write got %h want 0", wave_out); end
    n_vec++; if (sync !== 2'b00) begin n_err++; $display("FAIL reset_no_sync got %b want 0", sync); end
  endtask

  task automatic test_square();
    logic [7:0] ew;
    logic       es;
    cfg_write(1'b0, 2'd0, 32'h4000_0000);
    cfg_write(1'b0, 2'd1, 32'hA);
    for (int k = 1; k <= 16; k++) begin
      tick();
      ew = (k >= 3 && ((k - 3) % 4) < 2) ? 8'd255 : 8'd0;
      es = (k >= 7 && ((k - 3) % 4) == 0);
      n_vec++; if (wave_out[7:0] !== ew) begin n_err++; $display("FAIL square_wave k=%0d got %0d want %0d", k, wave_out[7:0], ew); end
      n_vec++; if (sync[0] !== es) begin n_err++; $display("FAIL square_sync k=%0d got %b want %b", k, sync[0], es); end
      n_vec++; if (wave_out[15:8] !== 8'd0) begin n_err++; $display("FAIL square_ch1_idle k=%0d got %0d want 0", k, wave_out[15:8]); end
    end
  endtask

  task automatic test_disable();
    logic [7:0]  ew;
    logic [10:0] ea;
    cfg_write(1'b0, 2'd1, 32'h2);
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (wave_out[7:0] !== 8'd0) begin n_err++; $display("FAIL disable_wave k=%0d got %0d want 0", k, wave_out[7:0]); end
      n_vec++; if (rom_addr[10:0] !== 11'd0) begin n_err++; $display("FAIL disable_addr k=%0d got %0d want 0", k, rom_addr[10:0]); end
      tick();
    end
    cfg_write(1'b0, 2'd1, 32'hA);
    for (int k = 1; k <= 8; k++) begin
      tick();
      ea = 11'(((k - 1) % 4) * 256);
      ew = (k >= 3 && ((k - 3) % 4) < 2) ? 8'd255 : 8'd0;
      n_vec++; if (rom_addr[10:0] !== ea) begin n_err++; $display("FAIL reenable_addr k=%0d got %0d want %0d", k, rom_addr[10:0], ea); end
      n_vec++; if (wave_out[7:0] !== ew) begin n_err++; $display("FAIL reenable_wave k=%0d got %0d want %0d", k, wave_out[7:0], ew); end
      n_vec++; if (sync[0] !== (k == 7)) begin n_err++; $display("FAIL reenable_sync k=%0d got %b want %b", k, sync[0], (k == 7)); end
    end
    cfg_write(1'b0, 2'd1, 32'h0);
  endtask

  task automatic test_sine_tri();
    logic [10:0] ea;
    logic [7:0]  ew;
    cfg_write(1'b0, 2'd0, 32'h0040_0000);
    cfg_write(1'b0, 2'd1, 32'h8);
    for (int k = 1; k <= 1030; k++) begin
      tick();
      ea = 11'((k - 1) % 1024);
      ew = (k >= 3) ? rom_fn(11'((k - 3) % 1024)) : 8'd0;
      n_vec++; if (rom_addr[10:0] !== ea) begin n_err++; $display("FAIL sine_addr k=%0d got %0d want %0d", k, rom_addr[10:0], ea); end
      n_vec++; if (wave_out[7:0] !== ew) begin n_err++; $display("FAIL sine_wave k=%0d got %0d want %0d", k, wave_out[7:0], ew); end
      n_vec++; if (sync[0] !== (k == 1027)) begin n_err++; $display("FAIL sine_sync k=%0d got %b want %b", k, sync[0], (k == 1027)); end
    end
    cfg_write(1'b0, 2'd1, 32'h1);
    cfg_write(1'b0, 2'd1, 32'h9);
    for (int k = 1; k <= 20; k++) begin
      tick();
      ea = 11'(1024 + k - 1);
      ew = (k >= 3) ? rom_fn(11'(1024 + k - 3)) : 8'd0;
      n_vec++; if (rom_addr[10:0] !== ea) begin n_err++; $display("FAIL tri_addr k=%0d got %0d want %0d", k, rom_addr[10:0], ea); end
      n_vec++; if (wave_out[7:0] !== ew) begin n_err++; $display("FAIL tri_wave k=%0d got %0d want %0d", k, wave_out[7:0], ew); end
    end
  endtask

  task automatic test_pwm();
    logic [7:0] ew;
    cfg_write(1'b0, 2'd1, 32'h3);
    cfg_write(1'b0, 2'd2, 32'd64);
    cfg_write(1'b0, 2'd0, 32'h0100_0000);
    cfg_write(1'b0, 2'd1, 32'hB);
    for (int k = 1; k <= 515; k++) begin
      tick();
      ew = (k >= 3 && ((k - 3) % 256) < 64) ? 8'd255 : 8'd0;
      n_vec++; if (wave_out[7:0] !== ew) begin n_err++; $display("FAIL pwm64 k=%0d got %0d want %0d", k, wave_out[7:0], ew); end
    end
    cfg_write(1'b0, 2'd1, 32'h3);
    cfg_write(1'b0, 2'd2, 32'd0);
    cfg_write(1'b0, 2'd1, 32'hB);
    for (int k = 1; k <= 300; k++) begin
      tick();
      n_vec++; if (wave_out[7:0] !== 8'd0) begin n_err++; $display("FAIL pwm0 k=%0d got %0d want 0", k, wave_out[7:0]); end
    end
  endtask

  task automatic test_saw_ch1();
    logic [7:0] ew;
    cfg_write(1'b1, 2'd0, 32'h0100_0000);
    cfg_write(1'b1, 2'd1, 32'hF);
    for (int k = 1; k <= 40; k++) begin
      tick();
      ew = (k >= 3) ? 8'((k - 3) % 256) : 8'd0;
      n_vec++; if (wave_out[15:8] !== ew) begin n_err++; $display("FAIL saw_ch1 k=%0d got %0d want %0d", k, wave_out[15:8], ew); end
      n_vec++; if (wave_out[7:0] !== 8'd0) begin n_err++; $display("FAIL saw_ch0_isolation k=%0d got %0d want 0", k, wave_out[7:0]); end
    end
    cfg_write(1'b1, 2'd1, 32'h0);
  endtask

  task automatic test_shadow();
    logic [7:0] ew;
    logic       es;
    int         m;
    cfg_write(1'b0, 2'd1, 32'h2);
    cfg_write(1'b0, 2'd0, 32'h1000_0000);
    cfg_write(1'b0, 2'd1, 32'hA);
    for (int k = 1; k <= 56; k++) begin
      cfg_valid = (k == 6 || k == 7 || k == 24);
      cfg_ch    = 1'b0;
      cfg_addr  = (k == 7) ? 2'd3 : 2'd0;
      cfg_data  = (k == 6) ? 32'h4000_0000 : (k == 7) ? 32'd127 : 32'h2000_0000;
      tick();
      cfg_valid = 1'b0;
      m = k - 3;
      if (k < 3) begin
        ew = 8'd0; es = 1'b0;
      end else if (m < 16) begin
        ew = ((m % 16) < 8) ? 8'd255 : 8'd0; es = 1'b0;
      end else if (m < 28) begin
        ew = (((m - 16) % 4) < 2) ? 8'd127 : 8'd0; es = (((m - 16) % 4) == 0);
      end else begin
        ew = (((m - 28) % 8) < 4) ? 8'd127 : 8'd0; es = (((m - 28) % 8) == 0);
      end
      n_vec++; if (wave_out[7:0] !== ew) begin n_err++; $display("FAIL shadow_wave k=%0d got %0d want %0d", k, wave_out[7:0], ew); end
      n_vec++; if (sync[0] !== es) begin n_err++; $display("FAIL shadow_sync k=%0d got %b want %b", k, sync[0], es); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_addr = 2'd0; cfg_data = 32'h0;
    test_reset();
    test_square();
    test_disable();
    test_sine_tri();
    test_pwm();
    test_saw_ch1();
    test_shadow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
